seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexes N_DIGITS BCD digits onto one shared 7-segment decoder and a

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 11 +
 rtl/seven_seg_scan_ctrl_scan_timer.sv | 48 ++++
 rtl/seven_seg_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Slot counter and digit index for the display scan; flags the last dead-time
// cycle, the end of each slot and the end of each frame.
module seven_seg_scan_ctrl_scan_timer
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int SLOT_CYCLES = 50000,
  parameter int N_DIGITS    = 4,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  output logic [$clog2(N_DIGITS)-1:0] idx_o,
  output logic                        last_dead_o,
  output logic                        slot_wrap_o,
  output logic                        frame_wrap_o
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign slot_wrap_o  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign frame_wrap_o = slot_wrap_o && (idx_q == IDX_W'(N_DIGITS - 1));
  assign last_dead_o  = (cnt_q == CNT_W'(DEAD_CYCLES - 1));
  assign idx_o        = idx_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_wrap_o) begin
      cnt_d = '0;
      idx_d = frame_wrap_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scans N_DIGITS BCD digits onto one shared decoder with dead time, leading-zero
// blanking, decimal points and frame-aligned value updates.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [4*N_DIGITS-1:0] upd_digits_i,
  input  logic [N_DIGITS-1:0]   upd_dp_i,
  input  logic                  lz_en_i,
  input  logic                  blank_all_i,
  output logic [3:0]            dec_code_o,
  output logic [N_DIGITS-1:0]   an_n_o,
  output logic                  dp_n_o,
  output logic                  frame_start_o
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = '1;

  logic [IDX_W-1:0] idx;
  logic             last_dead, slot_wrap, frame_wrap;

  scan_state_e state_q, state_d;

  logic [4*N_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic [4*N_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;

  logic [N_DIGITS-1:0] lz_blank;
  logic                lz_lead;
  logic [3:0]          cur_digit;

  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic [3:0]          dec_q, dec_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_start_q, frame_start_d;

  seven_seg_scan_ctrl_scan_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .N_DIGITS    (N_DIGITS),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .idx_o        (idx),
    .last_dead_o  (last_dead),
    .slot_wrap_o  (slot_wrap),
    .frame_wrap_o (frame_wrap)
  );

  // The state register stays aligned with the slot counter: DEAD while cnt < DEAD_CYCLES.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEAD:    if (last_dead) state_d = DRIVE;
      DRIVE:   if (slot_wrap) state_d = DEAD;
      default: state_d = DEAD;
    endcase
  end

  // Only a value already pending before the boundary cycle is promoted, so a
  // value accepted in that same cycle waits a full frame.
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_full_d   = pend_full_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    if (frame_wrap && pend_full_q) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      pend_full_d  = 1'b0;
    end
    if (upd_valid_i && !pend_full_q) begin
      pend_digits_d = upd_digits_i;
      pend_dp_d     = upd_dp_i;
      pend_full_d   = 1'b1;
    end
  end

  always_comb begin
    lz_blank = '0;
    lz_lead  = lz_en_i;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (act_digits_q[4*i +: 4] != 4'd0) lz_lead = 1'b0;
      lz_blank[i] = lz_lead;
    end
  end

  assign cur_digit = act_digits_q[{idx, 2'b00} +: 4];

  always_comb begin
    an_n_d        = AN_ALL_OFF;
    dec_d         = BLANK_CODE;
    dp_n_d        = 1'b1;
    frame_start_d = frame_wrap;
    if (state_q == DRIVE && !lz_blank[idx]) begin
      an_n_d[idx] = 1'b0;
      dec_d       = cur_digit;
      dp_n_d      = ~act_dp_q[idx];
    end
    if (blank_all_i) begin
      an_n_d = AN_ALL_OFF;
      dp_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= DEAD;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      act_digits_q  <= {N_DIGITS{BLANK_CODE}};
      act_dp_q      <= '0;
      an_n_q        <= AN_ALL_OFF;
      dec_q         <= BLANK_CODE;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      an_n_q        <= an_n_d;
      dec_q         <= dec_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign upd_ready_o   = !pend_full_q;
  assign an_n_o        = an_n_q;
  assign dec_code_o    = dec_q;
  assign dp_n_o        = dp_n_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles)
// with a small slot model and hand-picked display values.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_dp = '0;
  logic        lz_en = 1'b0;
  logic        blank_all = 1'b0;
  logic [3:0]  dec_code;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;
  logic multiAnode = 1'b0;

  seven_seg_scan_ctrl #(
    .N_DIGITS    (4),
    .SLOT_CYCLES (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .upd_valid_i   (upd_valid),
    .upd_ready_o   (upd_ready),
    .upd_digits_i  (upd_digits),
    .upd_dp_i      (upd_dp),
    .lz_en_i       (lz_en),
    .blank_all_i   (blank_all),
    .dec_code_o    (dec_code),
    .an_n_o        (an_n),
    .dp_n_o        (dp_n),
    .frame_start_o (frame_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(~an_n) > 1) multiAnode = 1'b1;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {an_n, dec_code, dp_n} for frame offset j (1..32) after a frame_start edge.
  function automatic logic [8:0] modelSlot(input logic [15:0] d, input logic [3:0] dpm,
                                           input logic lz, input int j);
    logic [3:0] blank;
    logic       seen;
    logic [3:0] dig;
    int c, s;
    blank = '0;
    seen  = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      dig = d[i*4 +: 4];
      if (dig != 4'd0) seen = 1'b1;
      else if (!seen && lz) blank[i] = 1'b1;
    end
    c = (j - 1) % 8;
    s = (j - 1) / 8;
    if (c < 2 || blank[s]) return {4'hF, 4'hF, 1'b1};
    return {~(4'b0001 << s), d[s*4 +: 4], ~dpm[s]};
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpm);
    int n;
    n = 0;
    upd_digits = d;
    upd_dp = dpm;
    while (!upd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyWait", upd_ready, 1);
    upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frameWait", frame_start, 1);
  endtask

  // Starts at the negedge where frame_start is seen and ends at the next one.
  task automatic checkFrame(input logic [15:0] d, input logic [3:0] dpm, input logic lz);
    logic [8:0] e;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      e = modelSlot(d, dpm, lz, j);
      checkOutput($sformatf("an_n %h j=%0d", d, j), an_n, e[8:5]);
      checkOutput($sformatf("dec_code %h j=%0d", d, j), dec_code, e[4:1]);
      checkOutput($sformatf("dp_n %h j=%0d", d, j), dp_n, e[0]);
      if (j == 16) checkOutput("frameStartMid", frame_start, 0);
    end
    checkOutput("framePeriod", frame_start, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rstAnN", an_n, 4'b1111);
    checkOutput("rstCode", dec_code, 4'hF);
    checkOutput("rstDpN", dp_n, 1);
    checkOutput("rstReady", upd_ready, 1);
    checkOutput("rstFrameStart", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("dark1", an_n, 4'b1111);
    @(negedge clk);
    checkOutput("dark2", an_n, 4'b1111);
    @(negedge clk);
    checkOutput("firstAnode", an_n, 4'b1110);
    checkOutput("firstCode", dec_code, 4'hF);

    applyStimulus(16'h1234, 4'b0100);
    waitFrame();
    checkFrame(16'h1234, 4'b0100, 1'b0);

    applyStimulus(16'h5678, 4'b0001);
    checkOutput("readyDrop", upd_ready, 0);
    fork
      applyStimulus(16'h9870, 4'b1000);
      begin
        waitFrame();
        checkFrame(16'h5678, 4'b0001, 1'b0);
      end
    join
    checkFrame(16'h9870, 4'b1000, 1'b0);

    fork
      begin
        repeat (31) @(negedge clk);
        applyStimulus(16'h0A07, 4'b0010);
      end
      checkFrame(16'h9870, 4'b1000, 1'b0);
    join
    checkFrame(16'h9870, 4'b1000, 1'b0);
    checkFrame(16'h0A07, 4'b0010, 1'b0);

    lz_en = 1'b1;
    applyStimulus(16'h0050, 4'b1000);
    waitFrame();
    checkFrame(16'h0050, 4'b1000, 1'b1);
    applyStimulus(16'h0000, 4'b0001);
    waitFrame();
    checkFrame(16'h0000, 4'b0001, 1'b1);

    repeat (4) @(negedge clk);
    checkOutput("preBlank", an_n, 4'b1110);
    blank_all = 1'b1;
    @(negedge clk);
    checkOutput("blankAnN", an_n, 4'b1111);
    checkOutput("blankDpN", dp_n, 1);
    blank_all = 1'b0;
    @(negedge clk);
    checkOutput("unblankAnN", an_n, 4'b1110);
    checkOutput("unblankDpN", dp_n, 0);
    repeat (25) @(negedge clk);
    checkOutput("blankFrameEarly", frame_start, 0);
    @(negedge clk);
    checkOutput("blankFramePeriod", frame_start, 1);
    checkFrame(16'h0000, 4'b0001, 1'b1);

    applyStimulus(16'h8888, 4'b1111);
    repeat (5) @(negedge clk);
    checkOutput("preResetAnN", an_n, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstAnN", an_n, 4'b1111);
    checkOutput("midRstCode", dec_code, 4'hF);
    checkOutput("midRstDpN", dp_n, 1);
    checkOutput("midRstReady", upd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    waitFrame();
    checkFrame(16'hFFFF, 4'b0000, 1'b1);

    checkOutput("singleAnode", multiAnode, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
